// File: rtl/lte_up_dfe_pkg.sv
// Shared definitions for the uplink DFE transposer scheduler: bandwidth
// mode codes, scheduler state encoding and the fixed transposer block length.
package lte_up_dfe_pkg;

    localparam logic [1:0] MOD_10M = 2'd1;
    localparam logic [1:0] MOD_15M = 2'd2;
    localparam logic [1:0] MOD_20M = 2'd3;

    // Transposer block length in cycles; the block counter is 6 bits wide.
    localparam int BLK_LEN = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } sched_state_e;

    // 10M and 15M use 16-cycle antenna slots (4 slots per block); 20M and
    // the unused code 0 use 8-cycle slots (8 slots per block).
    function automatic logic is_wide_slot(input logic [1:0] mode);
        return (mode == MOD_10M) || (mode == MOD_15M);
    endfunction

endpackage

// File: rtl/lte_up_dfe_frame_cnt.sv
// Radio-frame position counter with wrap detect and frame-pulse alignment
// compare. The counter is cleared by the scheduler whenever it is not
// counting, and it zeroes itself on any pulse seen while running.
import lte_up_dfe_pkg::*;

module lte_up_dfe_frame_cnt #(
    parameter int FRAME_LEN = 4915200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    input  logic frame_pulse,
    output logic wrap,
    output logic misalign,
    output logic realign
);

    localparam int                CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] frame_nxt_s;

    assign wrap     = (frame_cnt_r == LAST);
    // Any pulse while running re-anchors the frame; at the last cycle of the
    // frame this coincides with the natural wrap and changes nothing.
    assign realign  = run & frame_pulse;
    assign misalign = realign & ~wrap;

    // Next frame position: zero on clear/realign/wrap, otherwise advance.
    always_comb begin
        frame_nxt_s = frame_cnt_r;
        if (clr || realign || wrap) begin
            frame_nxt_s = ZERO;
        end else begin
            frame_nxt_s = frame_cnt_r + ONE;
        end
    end

    // Frame position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= ZERO;
        end else begin
            frame_cnt_r <= frame_nxt_s;
        end
    end

endmodule

// File: rtl/lte_up_dfe_trans_sched.sv
// Uplink DFE x8 transposer timing scheduler. Locks to the 10 ms frame pulse,
// generates block/antenna-slot framing strobes, applies the shadow bandwidth
// mode only on radio-frame boundaries and flags frame-pulse misalignment.
// All strobes are flops loaded from the next counter values, so each strobe
// is high in the same cycle the counters hold the decoded value.
import lte_up_dfe_pkg::*;

module lte_up_dfe_trans_sched #(
    parameter int FRAME_LEN = 4915200
) (
    input  logic       sys_clk_491p52,
    input  logic       sys_rst_491p52,
    input  logic       i_enable,
    input  logic       i_frame_pulse,
    input  logic [1:0] i_mod_sel_cfg,
    input  logic       i_cfg_update,
    output logic [1:0] o_mod_sel,
    output logic       o_fram,
    output logic       o_xant,
    output logic       o_frame_start,
    output logic [2:0] o_ant_idx,
    output logic       o_busy,
    output logic       o_err_sync
);

    localparam logic [5:0] BLK_LAST = 6'(BLK_LEN - 1);

    sched_state_e state_r;
    sched_state_e state_s;
    logic [5:0]   blk_cnt_r;
    logic [5:0]   blk_nxt_s;
    logic [1:0]   shadow_r;
    logic [1:0]   mode_nxt_s;
    logic         busy_nxt_s;
    logic         cnt_clr_s;
    logic         apply_s;
    logic         xant_s;
    logic [2:0]   ant_idx_s;
    logic         run_s;
    logic         wrap_s;
    logic         misalign_s;
    logic         realign_s;

    assign run_s = (state_r == RUN);

    lte_up_dfe_frame_cnt #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_cnt (
        .clk         (sys_clk_491p52),
        .rst_n       (sys_rst_491p52),
        .clr         (cnt_clr_s),
        .run         (run_s),
        .frame_pulse (i_frame_pulse),
        .wrap        (wrap_s),
        .misalign    (misalign_s),
        .realign     (realign_s)
    );

    // Scheduler state register.
    always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
        if (!sys_rst_491p52) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DRAIN always runs to the end of the current block.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_enable) state_s = WAIT_SYNC;
                else          state_s = IDLE;
            end
            WAIT_SYNC: begin
                if (!i_enable)          state_s = IDLE;
                else if (i_frame_pulse) state_s = RUN;
                else                    state_s = WAIT_SYNC;
            end
            RUN: begin
                if (!i_enable) state_s = DRAIN;
                else           state_s = RUN;
            end
            DRAIN: begin
                if (blk_cnt_r == BLK_LAST) state_s = IDLE;
                else                       state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next counter values, mode application and strobe decode.
    always_comb begin
        busy_nxt_s = (state_s == RUN) || (state_s == DRAIN);
        // Counters sit at zero while idle/waiting, restart on lock and
        // restart on a realigning pulse.
        cnt_clr_s  = !busy_nxt_s || (state_r == WAIT_SYNC) || realign_s;
        if (cnt_clr_s) blk_nxt_s = 6'd0;
        else           blk_nxt_s = blk_cnt_r + 6'd1;
        // Next frame position is zero exactly on clear or wrap.
        apply_s    = busy_nxt_s && (cnt_clr_s || wrap_s);
        if (apply_s) mode_nxt_s = shadow_r;
        else         mode_nxt_s = o_mod_sel;
        xant_s     = 1'b0;
        ant_idx_s  = 3'd0;
        if (!busy_nxt_s) begin
            xant_s    = 1'b0;
            ant_idx_s = 3'd0;
        end else if (is_wide_slot(mode_nxt_s)) begin
            xant_s    = (blk_nxt_s[3:0] == 4'd0);
            ant_idx_s = {1'b0, blk_nxt_s[5:4]};
        end else begin
            xant_s    = (blk_nxt_s[2:0] == 3'd0);
            ant_idx_s = blk_nxt_s[5:3];
        end
    end

    // Block counter register.
    always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
        if (!sys_rst_491p52) begin
            blk_cnt_r <= 6'd0;
        end else begin
            blk_cnt_r <= blk_nxt_s;
        end
    end

    // Shadow bandwidth mode, writable in any state.
    always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
        if (!sys_rst_491p52) begin
            shadow_r <= MOD_20M;
        end else if (i_cfg_update) begin
            shadow_r <= i_mod_sel_cfg;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Registered framing outputs and applied mode.
    always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
        if (!sys_rst_491p52) begin
            o_mod_sel     <= MOD_20M;
            o_fram        <= 1'b0;
            o_xant        <= 1'b0;
            o_frame_start <= 1'b0;
            o_ant_idx     <= 3'd0;
            o_busy        <= 1'b0;
        end else begin
            o_mod_sel     <= mode_nxt_s;
            o_fram        <= busy_nxt_s && (blk_nxt_s == 6'd0);
            o_xant        <= xant_s;
            o_frame_start <= apply_s;
            o_ant_idx     <= ant_idx_s;
            o_busy        <= busy_nxt_s;
        end
    end

    // Sticky misalignment flag; disabling the scheduler clears it.
    always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
        if (!sys_rst_491p52) begin
            o_err_sync <= 1'b0;
        end else if (!i_enable) begin
            o_err_sync <= 1'b0;
        end else if (misalign_s) begin
            o_err_sync <= 1'b1;
        end else begin
            o_err_sync <= o_err_sync;
        end
    end

endmodule

// File: doc/lte_up_dfe_trans_sched.md
Name: lte_up_dfe_trans_sched

Overview:
Timing scheduler for the uplink DFE x8 transposer on the 491.52 MHz domain. It locks to the 10 ms radio-frame pulse and generates the block framing strobes (o_fram, o_xant) that reset and pace the transposer write counter. It holds a shadow bandwidth-mode register that is applied only on radio-frame boundaries, and it monitors frame-pulse alignment. It sits between the frame-timing unit and the transposer input.

Parameters:
FRAME_LEN, 4915200, sys_clk_491p52 cycles per 10 ms radio frame; must be a multiple of 64 and at least 128.
BLK_LEN, 64, transposer block length in cycles; fixed at 64 (6-bit counter).

Ports:
sys_clk_491p52  in  1  491.52 MHz clock.
sys_rst_491p52  in  1  reset; asynchronous assert, active-low.
i_enable  in  1  run request; level.
i_frame_pulse  in  1  10 ms frame sync; one-cycle pulse.
i_mod_sel_cfg  in  2  requested mode: 1=10M, 2=15M, 3=20M, 0=treated as 20M.
i_cfg_update  in  1  one-cycle strobe; captures i_mod_sel_cfg into the shadow register.
o_mod_sel  out  2  applied mode, drives the transposer i_mod_sel.
o_fram  out  1  block start; one cycle when blk_cnt==0 in RUN.
o_xant  out  1  antenna-slot strobe.
o_frame_start  out  1  one cycle at radio-frame cycle 0.
o_ant_idx  out  3  current antenna slot index.
o_busy  out  1  high in RUN and DRAIN.
o_err_sync  out  1  sticky misalignment flag; cleared only when i_enable is low.

Behaviour:
- Reset values: all outputs 0, except o_mod_sel = 3. Shadow register = 3. State = IDLE. Counters = 0.
- Counters:
  - blk_cnt: 6 bits, wraps 63 to 0.
  - frame_cnt: 0..FRAME_LEN-1, wraps to 0.
  - Both increment only in RUN and DRAIN.
- States:
  - IDLE: o_busy=0, counters held at 0. If i_enable=1, go to WAIT_SYNC.
  - WAIT_SYNC: wait for i_frame_pulse. A pulse in cycle t moves to RUN at t+1. At t+1: blk_cnt=0, frame_cnt=0, o_fram=o_xant=o_frame_start=1, and o_mod_sel is loaded from the shadow in the same cycle. If i_enable drops, go to IDLE.
  - RUN:
    - o_fram = (blk_cnt==0).
    - o_xant: modes 1/2 assert when blk_cnt[3:0]==0 and o_ant_idx=blk_cnt[5:4]. Modes 3/0 assert when blk_cnt[2:0]==0 and o_ant_idx=blk_cnt[5:3].
    - o_frame_start = (frame_cnt==0).
    - At frame_cnt==0, o_mod_sel is loaded from the shadow register.
    - If i_enable=0, go to DRAIN.
  - DRAIN: keep generating strobes until blk_cnt==63, then go to IDLE. The final block is never truncated.
- All strobe outputs are registered: asserted in the same cycle the counter holds the stated value.
- Sync check, in RUN only:
  - Expected pulse: i_frame_pulse while frame_cnt==FRAME_LEN-1. This is normal and realign is a no-op.
  - Pulse at any other frame_cnt: set o_err_sync. Next cycle, force blk_cnt=0 and frame_cnt=0 and assert o_fram/o_xant/o_frame_start (immediate realign, no state change).
  - A missing pulse at frame_cnt==FRAME_LEN-1 is not an error: free-run continues.
  - Pulses in DRAIN are ignored.
- Shadow register and mode:
  - i_cfg_update loads the shadow in any state.
  - An update in the same cycle that the shadow is applied: o_mod_sel takes the old shadow value, and the new value applies at the next frame.
  - o_mod_sel never changes except at frame_cnt==0.
- o_err_sync: set as above; cleared in any cycle with i_enable=0.
- Reset mid-operation: immediate return to reset values. No strobe glitch, since outputs are flops.

Decomposition:
- Shared package lte_up_dfe_pkg:
  - Mode constants MOD_10M=2'd1, MOD_15M=2'd2, MOD_20M=2'd3.
  - State encoding IDLE/WAIT_SYNC/RUN/DRAIN.
  - BLK_LEN.
- One natural sub-module: lte_up_dfe_frame_cnt. It holds the frame counter, the wrap detect and the pulse-alignment compare, and outputs wrap, misalign and realign. The FSM and strobe decode stay in the top module.

Test Plan:
All scenarios use FRAME_LEN=256.
1. Bring-up: reset, i_enable=1, i_frame_pulse at cycle 10 -> o_fram/o_xant/o_frame_start high at cycle 11; o_fram every 64 cycles; o_frame_start every 256 cycles; o_busy=1.
2. Mode decode: mode 3 -> o_xant every 8 cycles with o_ant_idx 0..7. Set mode 1 via i_cfg_update mid-frame -> o_mod_sel stays 3 until the next o_frame_start, then o_xant every 16 cycles with o_ant_idx 0..3.
3. Aligned pulses: i_frame_pulse at frame_cnt==255 each frame -> o_err_sync stays 0 and the strobe period is unchanged.
4. Misaligned pulse at frame_cnt==100 -> o_err_sync=1; next cycle blk_cnt=0 and o_fram=o_frame_start=1. o_err_sync stays 1 until i_enable=0.
5. Drain: drop i_enable at blk_cnt==20 -> strobes continue through blk_cnt==63, then o_busy=0; no o_fram afterwards.
6. Async reset asserted in RUN -> all outputs 0 and o_mod_sel=3 immediately; after release and re-enable, lock again only on the next i_frame_pulse.
